// File: rtl/dram_ctrl.sv
// ============================================================================
//  Module   : dram_ctrl
//  Purpose  : Host-side initiator for the 8-bit DRAM model. Serialises host
//             RD/WR/MRW/MRR requests onto the DRAM pins, tracks RL/WL shadows.
//  Options  : DRAM_CTRL_RD_TIMEOUT_EN - bounded wait for read data.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_ctrl #(
   parameter int RL_RST = 8,
   parameter int WL_RST = 8,
   parameter int TO_CYC = 16
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       REQ_VALID,
   output logic       REQ_READY,
   input  logic [1:0] REQ_OP,
   input  logic [7:0] REQ_ADDR,
   input  logic [7:0] REQ_WDATA,
   output logic       RSP_VALID,
   output logic [7:0] RSP_RDATA,
   output logic       RSP_ERR,
   output logic       R,
   output logic       W,
   output logic       MRW,
   output logic       MRR,
   output logic [7:0] ADDR,
   output logic [7:0] DQ_IN,
   output logic       DRIV_VALID,
   input  logic       DQ_IE,
   input  logic [7:0] DQ_OUT,
   input  logic       DQ_OE,
   input  logic       DQ_OUT_VALID
);

   localparam logic [1:0] OP_RD  = 2'd0;
   localparam logic [1:0] OP_WR  = 2'd1;
   localparam logic [1:0] OP_MRW = 2'd2;
   localparam logic [1:0] OP_MRR = 2'd3;

   localparam logic [7:0] RL_RST_W = 8'(RL_RST);
   localparam logic [7:0] WL_RST_W = 8'(WL_RST);
   localparam logic [8:0] TO_W     = 9'(TO_CYC);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_WAIT  = 3'd1,
      WR_ACK   = 3'd2,
      RD_WAIT  = 3'd3,
      MRR_WAIT = 3'd4,
      RESP     = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] op_q, op_d;
   logic [8:0] cnt_q, cnt_d;
   logic [7:0] rl_sh_q, rl_sh_d;
   logic [7:0] wl_sh_q, wl_sh_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] dq_in_q, dq_in_d;
   logic       r_q, r_d, w_q, w_d, mrw_q, mrw_d, mrr_q, mrr_d;
   logic       driv_valid_q, driv_valid_d;
   logic       req_ready_q, req_ready_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic       rsp_err_q, rsp_err_d;
   logic [7:0] rsp_rdata_q, rsp_rdata_d;

   logic [8:0] cnt_inc;
   logic [8:0] rl_nom;
   logic [8:0] wl_ext;
   logic       unused_in;

   // Saturating so a long read wait can never wrap back into the valid window.
   assign cnt_inc   = (cnt_q == 9'h1FF) ? cnt_q : cnt_q + 9'd1;
   assign rl_nom    = {1'b0, rl_sh_q} + 9'd1;
   assign wl_ext    = {1'b0, wl_sh_q};
   assign unused_in = DQ_OUT_VALID ^ (^TO_W);

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      cnt_d        = cnt_q;
      rl_sh_d      = rl_sh_q;
      wl_sh_d      = wl_sh_q;
      addr_d       = addr_q;
      dq_in_d      = dq_in_q;
      r_d          = 1'b0;
      w_d          = 1'b0;
      mrw_d        = 1'b0;
      mrr_d        = 1'b0;
      driv_valid_d = 1'b0;
      req_ready_d  = req_ready_q;
      rsp_valid_d  = 1'b0;
      rsp_err_d    = rsp_err_q;
      rsp_rdata_d  = rsp_rdata_q;

      case (state_q)
         IDLE: begin
            if (REQ_VALID && req_ready_q) begin
               op_d        = REQ_OP;
               addr_d      = REQ_ADDR;
               dq_in_d     = REQ_WDATA;
               cnt_d       = 9'd0;
               req_ready_d = 1'b0;
               case (REQ_OP)
                  OP_RD: begin
                     r_d     = 1'b1;
                     state_d = RD_WAIT;
                  end
                  OP_WR: begin
                     w_d          = 1'b1;
                     driv_valid_d = (wl_sh_q == 8'd0);
                     state_d      = WR_WAIT;
                  end
                  OP_MRW: begin
                     mrw_d   = 1'b1;
                     state_d = MRR_WAIT;
                  end
                  OP_MRR: begin
                     mrr_d   = 1'b1;
                     state_d = MRR_WAIT;
                  end
               endcase
            end
         end

         WR_WAIT: begin
            cnt_d = cnt_inc;
            if (cnt_q == wl_ext) begin
               state_d = WR_ACK;
            end else begin
               driv_valid_d = ((cnt_q + 9'd1) == wl_ext);
            end
         end

         WR_ACK: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 8'h00;
            rsp_err_d   = !DQ_IE;
         end

         RD_WAIT: begin
            cnt_d = cnt_inc;
            if (DQ_OE) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = DQ_OUT;
               rsp_err_d   = (cnt_q < rl_nom);
            end
`ifdef DRAM_CTRL_RD_TIMEOUT_EN
            else if (cnt_q == ({1'b0, rl_sh_q} + TO_W)) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = 8'h00;
               rsp_err_d   = 1'b1;
            end
`endif
         end

         // Shared by MRW (finishes after cycle 0) and MRR (samples in cycle 1).
         MRR_WAIT: begin
            cnt_d = cnt_inc;
            if (op_q == OP_MRW) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = 8'h00;
               rsp_err_d   = (addr_q > 8'd1);
               if (addr_q == 8'd0) rl_sh_d = dq_in_q;
               if (addr_q == 8'd1) wl_sh_d = dq_in_q;
            end else if (cnt_q == 9'd1) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = (addr_q > 8'd1) ? 8'h00 : DQ_OUT;
               rsp_err_d   = (addr_q > 8'd1);
            end
         end

         RESP: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end

         default: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= IDLE;
         op_q         <= OP_RD;
         cnt_q        <= 9'd0;
         rl_sh_q      <= RL_RST_W;
         wl_sh_q      <= WL_RST_W;
         addr_q       <= 8'h00;
         dq_in_q      <= 8'h00;
         r_q          <= 1'b0;
         w_q          <= 1'b0;
         mrw_q        <= 1'b0;
         mrr_q        <= 1'b0;
         driv_valid_q <= 1'b0;
         req_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_rdata_q  <= 8'h00;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         cnt_q        <= cnt_d;
         rl_sh_q      <= rl_sh_d;
         wl_sh_q      <= wl_sh_d;
         addr_q       <= addr_d;
         dq_in_q      <= dq_in_d;
         r_q          <= r_d;
         w_q          <= w_d;
         mrw_q        <= mrw_d;
         mrr_q        <= mrr_d;
         driv_valid_q <= driv_valid_d;
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_err_q    <= rsp_err_d;
         rsp_rdata_q  <= rsp_rdata_d;
      end
   end

   assign REQ_READY  = req_ready_q;
   assign RSP_VALID  = rsp_valid_q;
   assign RSP_RDATA  = rsp_rdata_q;
   assign RSP_ERR    = rsp_err_q;
   assign R          = r_q;
   assign W          = w_q;
   assign MRW        = mrw_q;
   assign MRR        = mrr_q;
   assign ADDR       = addr_q;
   assign DQ_IN      = dq_in_q;
   assign DRIV_VALID = driv_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_dram_ctrl.sv
// ============================================================================
//  Module   : tb_dram_ctrl
//  Purpose  : Directed self-checking bench for dram_ctrl with a cycle-level
//             DRAM model (RL/WL mode registers, 256-byte array).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dram_ctrl;

   localparam logic [1:0] OP_RD  = 2'd0;
   localparam logic [1:0] OP_WR  = 2'd1;
   localparam logic [1:0] OP_MRW = 2'd2;
   localparam logic [1:0] OP_MRR = 2'd3;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       REQ_VALID = 1'b0;
   logic       REQ_READY;
   logic [1:0] REQ_OP = 2'd0;
   logic [7:0] REQ_ADDR = 8'h00;
   logic [7:0] REQ_WDATA = 8'h00;
   logic       RSP_VALID;
   logic [7:0] RSP_RDATA;
   logic       RSP_ERR;
   logic       R, W, MRW, MRR;
   logic [7:0] ADDR;
   logic [7:0] DQ_IN;
   logic       DRIV_VALID;
   logic       DQ_IE = 1'b0;
   logic [7:0] DQ_OUT = 8'h00;
   logic       DQ_OE = 1'b0;
   logic       DQ_OUT_VALID = 1'b0;

   dram_ctrl dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .REQ_VALID    (REQ_VALID),
      .REQ_READY    (REQ_READY),
      .REQ_OP       (REQ_OP),
      .REQ_ADDR     (REQ_ADDR),
      .REQ_WDATA    (REQ_WDATA),
      .RSP_VALID    (RSP_VALID),
      .RSP_RDATA    (RSP_RDATA),
      .RSP_ERR      (RSP_ERR),
      .R            (R),
      .W            (W),
      .MRW          (MRW),
      .MRR          (MRR),
      .ADDR         (ADDR),
      .DQ_IN        (DQ_IN),
      .DRIV_VALID   (DRIV_VALID),
      .DQ_IE        (DQ_IE),
      .DQ_OUT       (DQ_OUT),
      .DQ_OE        (DQ_OE),
      .DQ_OUT_VALID (DQ_OUT_VALID)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Monitor state (relative cycles are counted from the command cycle).
   int         cyc = 0;
   int         cmd_cyc = 0;
   logic [3:0] cmd_vec = 4'h0;
   logic [7:0] cmd_addr = 8'h00;
   bit         busy = 1'b0;
   int         dv_rel = -1, oe_rel = -1, rsp_rel = -1;
   int         dv_n = 0, rsp_n = 0;
   int         ovl_bad = 0, rdy_bad = 0, addr_bad = 0;
   logic [7:0] rsp_data = 8'h00;
   logic       rsp_err = 1'b0;

   // DRAM model state
   logic [7:0] mem [0:255] = '{default: 8'h00};
   logic [7:0] m_rl = 8'd8, m_wl = 8'd8;
   int         rd_at = -1, wr_at = -1, ie_at = -1, mrr_at = -1;
   logic [7:0] rd_addr = 8'h00, mrr_addr = 8'h00;
   int         oe_shift = 0;

   always @(negedge CLK) begin
      cyc++;
      if (!RST_N) begin
         busy  = 1'b0;
         m_rl  = 8'd8;
         m_wl  = 8'd8;
         rd_at = -1; wr_at = -1; ie_at = -1; mrr_at = -1;
         DQ_OE = 1'b0; DQ_IE = 1'b0; DQ_OUT = 8'h00;
      end else begin
         if ((32'(R) + 32'(W) + 32'(MRW) + 32'(MRR)) > 1) ovl_bad++;
         if (R || W || MRW || MRR) begin
            if (busy) ovl_bad++;
            busy     = 1'b1;
            cmd_cyc  = cyc;
            cmd_vec  = {R, W, MRW, MRR};
            cmd_addr = ADDR;
            dv_rel   = -1;
            oe_rel   = -1;
         end
         if (busy && REQ_READY) rdy_bad++;
         if (busy && ADDR != cmd_addr) addr_bad++;
         if (DRIV_VALID) begin
            dv_n++;
            dv_rel = cyc - cmd_cyc;
         end
         if (RSP_VALID) begin
            rsp_n++;
            rsp_rel  = cyc - cmd_cyc;
            rsp_data = RSP_RDATA;
            rsp_err  = RSP_ERR;
            busy     = 1'b0;
         end
         DQ_OE = 1'b0;
         DQ_IE = 1'b0;
         if (R) begin
            rd_at   = cyc + int'(m_rl) + 1 + oe_shift;
            rd_addr = ADDR;
         end
         if (W) wr_at = cyc + int'(m_wl);
         if (MRW) begin
            if (ADDR == 8'd0) m_rl = DQ_IN;
            if (ADDR == 8'd1) m_wl = DQ_IN;
         end
         if (MRR) begin
            mrr_at   = cyc + 1;
            mrr_addr = ADDR;
         end
         if (DRIV_VALID && cyc == wr_at) begin
            mem[ADDR] = DQ_IN;
            ie_at     = cyc + 1;
         end
         if (cyc == ie_at) DQ_IE = 1'b1;
         if (cyc == rd_at) begin
            DQ_OE  = 1'b1;
            DQ_OUT = mem[rd_addr];
            oe_rel = cyc - cmd_cyc;
         end
         if (cyc == mrr_at)
            DQ_OUT = (mrr_addr == 8'd0) ? m_rl : (mrr_addr == 8'd1) ? m_wl : 8'hEE;
      end
   end

   // Presents a request and returns at the mid-point of its command cycle,
   // with REQ_VALID still asserted.
   task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
      int n;
      @(negedge CLK);
      REQ_VALID = 1'b1;
      REQ_OP    = op;
      REQ_ADDR  = a;
      REQ_WDATA = d;
      n = 0;
      while (!REQ_READY && n < 200) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 200) chk("accept_bound", 32'(REQ_READY), 32'd1);
      @(negedge CLK);
   endtask

   task automatic wait_rsp(input int target);
      int n;
      n = 0;
      while (rsp_n < target && n < 600) begin
         @(posedge CLK);
         n++;
      end
      if (rsp_n < target) chk("rsp_bound", 32'(rsp_n), 32'(target));
   endtask

   task automatic do_req(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
      int t;
      t = rsp_n + 1;
      issue(op, a, d);
      REQ_VALID = 1'b0;
      wait_rsp(t);
   endtask

   initial begin
      int dv0, rsp0;
      RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_ready", 32'(REQ_READY), 32'd1);
      chk("rst_strobes", 32'({R, W, MRW, MRR, DRIV_VALID, RSP_VALID, RSP_ERR}), 32'd0);
      chk("rst_data", {8'h00, ADDR, DQ_IN, RSP_RDATA}, 32'd0);
      RST_N = 1'b1;

      // Reset latencies RL=WL=8
      do_req(OP_WR, 8'h12, 8'hA5);
      chk("wr_cmd", 32'(cmd_vec), 32'b0100);
      chk("wr_dv_rel", 32'(dv_rel), 32'd8);
      chk("wr_dv_n", 32'(dv_n), 32'd1);
      chk("wr_rsp_rel", 32'(rsp_rel), 32'd10);
      chk("wr_err", 32'(rsp_err), 32'd0);
      chk("wr_rdata", 32'(rsp_data), 32'd0);
      chk("wr_addr_hold", 32'(addr_bad), 32'd0);
      do_req(OP_RD, 8'h12, 8'h00);
      chk("rd_cmd", 32'(cmd_vec), 32'b1000);
      chk("rd_data", 32'(rsp_data), 32'hA5);
      chk("rd_err", 32'(rsp_err), 32'd0);
      chk("rd_rsp_rel", 32'(rsp_rel), 32'd10);

      // RL=3
      do_req(OP_MRW, 8'd0, 8'd3);
      chk("mrw0_cmd", 32'(cmd_vec), 32'b0010);
      chk("mrw0_rel", 32'(rsp_rel), 32'd1);
      chk("mrw0_err", 32'(rsp_err), 32'd0);
      do_req(OP_RD, 8'h12, 8'h00);
      chk("rd3_oe_rel", 32'(oe_rel), 32'd4);
      chk("rd3_rsp", {15'd0, rsp_err, rsp_data, 8'(rsp_rel)}, {15'd0, 1'b0, 8'hA5, 8'd5});
      do_req(OP_MRR, 8'd0, 8'h00);
      chk("mrr0_cmd", 32'(cmd_vec), 32'b0001);
      chk("mrr0_rsp", {15'd0, rsp_err, rsp_data, 8'(rsp_rel)}, {15'd0, 1'b0, 8'h03, 8'd2});

      // WL=0
      do_req(OP_MRW, 8'd1, 8'd0);
      chk("mrw1_err", 32'(rsp_err), 32'd0);
      dv0 = dv_n;
      do_req(OP_WR, 8'h40, 8'h3C);
      chk("wl0_dv_rel", 32'(dv_rel), 32'd0);
      chk("wl0_dv_n", 32'(dv_n - dv0), 32'd1);
      chk("wl0_rsp", {15'd0, rsp_err, 8'd0, 8'(rsp_rel)}, {15'd0, 1'b0, 8'd0, 8'd2});
      do_req(OP_RD, 8'h40, 8'h00);
      chk("rd40_data", {23'd0, rsp_err, rsp_data}, {23'd0, 1'b0, 8'h3C});

      // Back-to-back writes with REQ_VALID held throughout
      rsp0 = rsp_n;
      issue(OP_WR, 8'h41, 8'h11);
      issue(OP_WR, 8'h42, 8'h22);
      REQ_VALID = 1'b0;
      wait_rsp(rsp0 + 2);
      chk("b2b_rsp_n", 32'(rsp_n - rsp0), 32'd2);
      chk("b2b_ready_low", 32'(rdy_bad), 32'd0);
      chk("b2b_overlap", 32'(ovl_bad), 32'd0);
      chk("b2b_addr_hold", 32'(addr_bad), 32'd0);
      do_req(OP_RD, 8'h41, 8'h00);
      chk("b2b_rd41", 32'(rsp_data), 32'h11);
      do_req(OP_RD, 8'h42, 8'h00);
      chk("b2b_rd42", 32'(rsp_data), 32'h22);

      // Bad MR indices
      do_req(OP_MRW, 8'd5, 8'd9);
      chk("mrw5_err", 32'(rsp_err), 32'd1);
      do_req(OP_MRR, 8'd7, 8'h00);
      chk("mrr7_rsp", {23'd0, rsp_err, rsp_data}, {23'd0, 1'b1, 8'h00});

      // Early read data (RL=3, DQ_OE in cycle 3)
      oe_shift = -1;
      do_req(OP_RD, 8'h12, 8'h00);
      oe_shift = 0;
      chk("early_rsp", {15'd0, rsp_err, rsp_data, 8'(rsp_rel)}, {15'd0, 1'b1, 8'hA5, 8'd4});

      // Read data far later than nominal (RL=8, DQ_OE in cycle 39)
      do_req(OP_MRW, 8'd0, 8'd8);
      oe_shift = 30;
      do_req(OP_RD, 8'h12, 8'h00);
      oe_shift = 0;
`ifdef DRAM_CTRL_RD_TIMEOUT_EN
      chk("timeout_rsp", {15'd0, rsp_err, rsp_data, 8'(rsp_rel)}, {15'd0, 1'b1, 8'h00, 8'd25});
      repeat (20) @(posedge CLK);
`else
      chk("late_rsp", {15'd0, rsp_err, rsp_data, 8'(rsp_rel)}, {15'd0, 1'b0, 8'hA5, 8'd40});
`endif

      // Reset in cycle 4 of a WL=8 write, with RL shadow moved to 5
      do_req(OP_MRW, 8'd0, 8'd5);
      do_req(OP_MRW, 8'd1, 8'd8);
      dv0  = dv_n;
      rsp0 = rsp_n;
      issue(OP_WR, 8'h50, 8'h77);
      REQ_VALID = 1'b0;
      repeat (4) @(negedge CLK);
      RST_N = 1'b0;
      #1;
      chk("mid_rst_strobes", 32'({R, W, MRW, MRR, DRIV_VALID, RSP_VALID}), 32'd0);
      chk("mid_rst_ready", 32'(REQ_READY), 32'd1);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      repeat (20) @(posedge CLK);
      chk("mid_rst_no_dv", 32'(dv_n - dv0), 32'd0);
      chk("mid_rst_no_rsp", 32'(rsp_n - rsp0), 32'd0);
      do_req(OP_MRR, 8'd1, 8'h00);
      chk("mid_rst_mrr1", {23'd0, rsp_err, rsp_data}, {23'd0, 1'b0, 8'd8});
      do_req(OP_RD, 8'h50, 8'h00);
      chk("mid_rst_rd50", {15'd0, rsp_err, rsp_data, 8'(rsp_rel)}, {15'd0, 1'b0, 8'h00, 8'd10});

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dram_ctrl.md
Name: dram_ctrl

Overview:
- Host-side initiator for the 8-bit DRAM model.
- Accepts one host request at a time over a valid/ready port: read, write, mode-register write (MRW) or mode-register read (MRR).
- Drives the DRAM command pins, times write data and DRIV_VALID against the write latency (WL), and captures read data at the read latency (RL).
- Keeps RL/WL shadow copies updated by its own MRW commands; returns one response per request.

Parameters:
- RL_RST, 8, shadow RL after reset; must equal the DRAM's reset RL.
- WL_RST, 8, shadow WL after reset; must equal the DRAM's reset WL.
- TO_CYC, 16, extra cycles beyond the expected read-data cycle before a read is declared failed.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset; asynchronous assert, active-low.
- REQ_VALID  in  1  host request valid.
- REQ_READY  out  1  controller can accept a request.
- REQ_OP  in  2  operation: 0=RD, 1=WR, 2=MRW, 3=MRR.
- REQ_ADDR  in  8  array address, or MR index (0=RL, 1=WL).
- REQ_WDATA  in  8  write data or MR value.
- RSP_VALID  out  1  one-cycle response pulse.
- RSP_RDATA  out  8  read or MRR data; 0 for WR/MRW.
- RSP_ERR  out  1  error flag, qualified by RSP_VALID.
- R, W, MRW, MRR  out  1 each  DRAM command strobes.
- ADDR  out  8  DRAM address.
- DQ_IN  out  8  DRAM write/MR data.
- DRIV_VALID  out  1  write-data drive strobe.
- DQ_IE  in  1  DRAM write-accept indication.
- DQ_OUT  in  8  DRAM read data.
- DQ_OE  in  1  DRAM read-data valid.
- DQ_OUT_VALID  in  1  DRAM output-window flag; unused internally.

Behaviour:
- Reset values:
  - All outputs 0, except REQ_READY=1.
  - rl_sh=RL_RST, wl_sh=WL_RST.
  - State IDLE.
- States: IDLE, WR_WAIT, WR_ACK, RD_WAIT, MRR_WAIT, RESP.
- Accept: a request is accepted when REQ_VALID && REQ_READY. REQ_READY=1 only in IDLE.
- Command cycle (cycle 0) is the cycle after accept:
  - Exactly one command strobe is high, for one cycle.
  - ADDR=REQ_ADDR and DQ_IN=REQ_WDATA, both latched at accept.
- ADDR and DQ_IN hold their value until the response is issued. The DRAM writes to the live ADDR, so ADDR must not change before commit.
- WR:
  - W=1 in cycle 0. DRIV_VALID=1 only in cycle wl_sh; when wl_sh=0 this is cycle 0 itself.
  - WR_WAIT counts to wl_sh, then moves to WR_ACK.
  - WR_ACK expects DQ_IE=1 in cycle wl_sh+1. Response: RSP_ERR = !DQ_IE.
- RD:
  - R=1 in cycle 0. RD_WAIT counts cycles from cycle 0.
  - The first cycle with DQ_OE=1 captures DQ_OUT into RSP_RDATA, RSP_ERR=0. The nominal cycle is rl_sh+1.
  - DQ_OE seen before cycle rl_sh+1 is still captured, but RSP_ERR=1 (latency mismatch).
- MRW:
  - MRW=1 in cycle 0.
  - ADDR 0 loads rl_sh and ADDR 1 loads wl_sh from DQ_IN at the end of cycle 0.
  - Other indices: command is still issued, no shadow update, RSP_ERR=1.
  - Response in cycle 1.
- MRR:
  - MRR=1 in cycle 0. MRR_WAIT samples DQ_OUT in cycle 1 into RSP_RDATA.
  - ADDR>1 gives RSP_RDATA=0, RSP_ERR=1.
- RESP:
  - RSP_VALID=1 for exactly one cycle, then IDLE.
  - RSP_RDATA/RSP_ERR hold until the next response.
  - Earliest next accept is in the cycle after RSP_VALID.
- Counter: 9 bits, so RL=255 plus TO_CYC cannot wrap early; it saturates.
- Illegal or X REQ_OP cannot occur (2-bit, fully decoded). REQ_VALID while busy is ignored; the host must hold it.
- Reset mid-operation: all strobes drop immediately (async). Any pending DRIV_VALID is cancelled, no response is issued, and the shadows return to reset values.

Optional Feature:
- DRAM_CTRL_RD_TIMEOUT_EN.
- Defined:
  - If no DQ_OE by cycle rl_sh+1+TO_CYC, RD terminates with RSP_VALID=1, RSP_ERR=1, RSP_RDATA=0.
  - In WR_ACK, a missing DQ_IE likewise errors (this is already the baseline behaviour).
- Undefined:
  - RD_WAIT waits indefinitely for DQ_OE; no timeout logic or TO_CYC compare is synthesised.

Test Plan:
- After reset: WR addr 0x12 data 0xA5, then RD 0x12 -> W in cycle 0, DRIV_VALID only in cycle 8, ADDR=0x12 held through cycle 9; read RSP_RDATA=0xA5, RSP_ERR=0, RSP_VALID 10 cycles after R.
- MRW idx0 data 3, then RD -> R-to-DQ_OE capture 4 cycles; MRR idx0 -> RSP_RDATA=0x03.
- MRW idx1 data 0, then WR 0x40 data 0x3C -> W and DRIV_VALID both in cycle 0; a subsequent RD 0x40 returns 0x3C.
- Host holds REQ_VALID over back-to-back WR requests -> REQ_READY low from accept to RSP_VALID; no command overlaps; each ADDR is stable for its full window.
- DQ_OE tied 0 with DRAM_CTRL_RD_TIMEOUT_EN, RL=8, TO_CYC=16 -> RSP_VALID with RSP_ERR=1 and RSP_RDATA=0 at cycle 25.
- RST_N pulsed low in cycle 4 of a WR with WL=8 -> DRIV_VALID never asserts; no RSP_VALID; MRR idx1 afterwards returns 8.
